// File: rtl/c4_move_rx.sv
// c4_move_rx: synchronise and debounce the host column strobe, range-check it, and queue moves for the core.
// Define MOVE_ECHO_EN to add the echo_col/echo_vld readback of the last accepted column.
module c4_move_rx #(
    parameter int COLS = 7,
    parameter int DEBOUNCE = 4,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       pin_strb,
    input  logic [2:0] pin_col,
    output logic       move_valid,
    output logic [2:0] move_col,
    input  logic       move_ready,
    output logic       host_busy,
    output logic       err_col,
    output logic       dropped,
    output logic [2:0] echo_col,
    output logic       echo_vld
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE);
    localparam logic [NW-1:0] FULL = NW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic strb_s1, strb_s2;
    logic [2:0] col_s1, col_s2;
    logic [2:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [NW-1:0] count, count_n;
    logic qualify, bad_col, pop, push, drop;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        qualify = 1'b0;
        if (!ena) begin
            state_n = IDLE;
            cnt_n = '0;
        end else begin
            case (state)
                IDLE: if (strb_s2) begin
                    state_n = RISE;
                    cnt_n = ONE;
                end
                RISE: if (!strb_s2) begin
                    state_n = IDLE;
                    cnt_n = '0;
                end else if (cnt == DB) begin
                    qualify = 1'b1;
                    state_n = HOLD;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
                HOLD: if (strb_s2) begin
                    cnt_n = '0;
                end else if (cnt + ONE == DB) begin
                    state_n = IDLE;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n = '0;
                end
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign bad_col = int'(col_s2) >= COLS;
    assign move_valid = count != '0;
    assign pop = move_valid & move_ready;
    assign push = qualify & !bad_col & ((count != FULL) | pop);
    assign drop = qualify & !bad_col & !push;
    assign count_n = count + NW'(push) - NW'(pop);
    assign move_col = move_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strb_s1 <= 1'b0;
            strb_s2 <= 1'b0;
            col_s1 <= '0;
            col_s2 <= '0;
            state <= IDLE;
            cnt <= '0;
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            host_busy <= 1'b0;
            err_col <= 1'b0;
            dropped <= 1'b0;
        end else begin
            strb_s1 <= pin_strb;
            strb_s2 <= strb_s1;
            col_s1 <= pin_col;
            col_s2 <= col_s1;
            state <= state_n;
            cnt <= cnt_n;
            wptr <= wptr + AW'(push);
            rptr <= rptr + AW'(pop);
            count <= count_n;
            host_busy <= count_n == FULL;
            err_col <= qualify & bad_col;
            dropped <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= col_s2;
    end

`ifdef MOVE_ECHO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_col <= '0;
            echo_vld <= 1'b0;
        end else if (push) begin
            echo_col <= col_s2;
            echo_vld <= 1'b1;
        end
    end
`else
    assign echo_col = '0;
    assign echo_vld = 1'b0;
`endif
endmodule
